// File: rtl/tube_pkg.sv
// Shared constants for the tube scanner: digit positions and 7-segment codes.
package tube_pkg;

  localparam logic [2:0] DIG_SEC_ONES  = 3'd0;
  localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
  localparam logic [2:0] DIG_MIN_ONES  = 3'd2;
  localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
  localparam logic [2:0] DIG_HOUR_ONES = 3'd4;
  localparam logic [2:0] DIG_HOUR_TENS = 3'd5;

  // Segment g alone: shown on both digits of an out-of-range value.
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Segment code table, bit order g..a, active-high.
  function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd7.sv
// Combinational 7-bit binary to two BCD digits, with an out-of-range flag.
module bin2bcd7 (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       over99
);

  // Tens by threshold compare, ones as the remainder; both are don't-care above 99.
  always_comb begin
    tens = 4'd0;
    for (int i = 1; i <= 9; i++) begin
      if (bin >= 7'(10 * i)) tens = 4'(i);
    end
    ones   = 4'(bin - 7'(tens) * 7'd10);
    over99 = bin > 7'd99;
  end

endmodule

// File: rtl/tube_scanner.sv
// Multiplexed 6-digit nixie/7-seg scanner for seconds, minutes and hours,
// with frame-coherent snapshots and blinking of the fields being set.
module tube_scanner
  import tube_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  sec_count,
  input  logic [6:0]  min_count,
  input  logic [6:0]  hour_count,
  input  logic        is_manual_set,
  output logic [10:0] tube_11bit
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] presc;
  logic [2:0]    dig_idx, dig_next;
  logic [FW-1:0] frame_cnt, frame_cnt_next;
  logic          blink, blink_next, manual_q;
  logic [6:0]    snap_sec, snap_min, snap_hour;
  logic [6:0]    nsnap_sec, nsnap_min, nsnap_hour;
  logic          scan_tick, frame_start, manual_rise;
  logic [6:0]    sel_val;
  logic [3:0]    bcd_tens, bcd_ones;
  logic          bcd_over99;
  logic [6:0]    seg;
  logic          dp, blank;
  logic [10:0]   tube_next;

  assign scan_tick   = (presc == PRESC_LAST);
  assign dig_next    = (dig_idx == DIG_HOUR_TENS) ? DIG_SEC_ONES : dig_idx + 3'd1;
  assign frame_start = scan_tick && (dig_idx == DIG_HOUR_TENS);
  assign manual_rise = is_manual_set && !manual_q;

  // Snapshot reloads at frame start so digit 0 already shows the fresh value.
  always_comb begin
    nsnap_sec  = snap_sec;
    nsnap_min  = snap_min;
    nsnap_hour = snap_hour;
    if (frame_start) begin
      nsnap_sec  = sec_count;
      nsnap_min  = min_count;
      nsnap_hour = hour_count;
    end
  end

  // Pick the snapshot field belonging to the digit about to be shown.
  always_comb begin
    case (dig_next)
      DIG_SEC_ONES, DIG_SEC_TENS: sel_val = nsnap_sec;
      DIG_MIN_ONES, DIG_MIN_TENS: sel_val = nsnap_min;
      default:                    sel_val = nsnap_hour;
    endcase
  end

  bin2bcd7 u_bin2bcd7 (
    .bin    (sel_val),
    .tens   (bcd_tens),
    .ones   (bcd_ones),
    .over99 (bcd_over99)
  );

  // Blink phase: toggles every BLINK_FRAMES frames; a new set session restarts visible.
  always_comb begin
    frame_cnt_next = frame_cnt;
    blink_next     = blink;
    if (manual_rise) begin
      frame_cnt_next = '0;
      blink_next     = 1'b0;
    end else if (frame_start) begin
      if (frame_cnt >= FRAME_LAST) begin
        frame_cnt_next = '0;
        blink_next     = ~blink;
      end else begin
        frame_cnt_next = frame_cnt + FW'(1);
      end
    end
  end

  // Assemble the next tube word; odd indices are tens digits.
  always_comb begin
    if (bcd_over99)       seg = SEG_DASH;
    else if (dig_next[0]) seg = seg_encode(bcd_tens);
    else                  seg = seg_encode(bcd_ones);
    dp        = (dig_next == DIG_MIN_ONES) || (dig_next == DIG_HOUR_ONES);
    blank     = is_manual_set && blink_next && (dig_next >= DIG_MIN_ONES);
    tube_next = blank ? {dig_next, 8'h00} : {dig_next, dp, seg};
  end

  // Prescaler, digit index and display register; display moves only on a scan tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc      <= '0;
      dig_idx    <= DIG_SEC_ONES;
      tube_11bit <= 11'h000;
    end else begin
      presc <= scan_tick ? '0 : presc + PW'(1);
      if (scan_tick) begin
        dig_idx    <= dig_next;
        tube_11bit <= tube_next;
      end
    end
  end

  // Snapshot, frame counter, blink phase and set-mode edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_sec  <= '0;
      snap_min  <= '0;
      snap_hour <= '0;
      frame_cnt <= '0;
      blink     <= 1'b0;
      manual_q  <= 1'b0;
    end else begin
      snap_sec  <= nsnap_sec;
      snap_min  <= nsnap_min;
      snap_hour <= nsnap_hour;
      frame_cnt <= frame_cnt_next;
      blink     <= blink_next;
      manual_q  <= is_manual_set;
    end
  end

endmodule

// File: tb/tb_tube_scanner.sv
// Self-checking bench for tube_scanner: frame tables, corner sequences and a
// cycle-level reference model running under random stimulus.
module tb_tube_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  sec_count = '0, min_count = '0, hour_count = '0;
  logic        is_manual_set = 1'b0;
  logic [10:0] tube_11bit;

  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [6:0]      sec, min, hour;
    logic [5:0][6:0] seg;
  } vec_t;

  vec_t recs [7];

  tube_scanner #(.SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk           (clk),
    .rst           (rst),
    .sec_count     (sec_count),
    .min_count     (min_count),
    .hour_count    (hour_count),
    .is_manual_set (is_manual_set),
    .tube_11bit    (tube_11bit)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; default: return 7'h6F;
    endcase
  endfunction

  function automatic logic [10:0] model_digit(input int dig, input int s, input int m,
                                              input int h, input logic blank);
    int         v;
    logic [6:0] sg;
    logic       dpl;
    v   = (dig < 2) ? s : (dig < 4) ? m : h;
    sg  = (v > 99) ? 7'h40 : seg_of((dig % 2 == 0) ? v % 10 : v / 10);
    dpl = (dig == 2) || (dig == 4);
    if (blank && dig >= 2) return {3'(dig), 8'h00};
    return {3'(dig), dpl, sg};
  endfunction

  function automatic vec_t mk(input int s, input int m, input int h,
                              input logic [6:0] d0, input logic [6:0] d1, input logic [6:0] d2,
                              input logic [6:0] d3, input logic [6:0] d4, input logic [6:0] d5);
    vec_t v;
    v.sec = 7'(s); v.min = 7'(m); v.hour = 7'(h);
    v.seg[0] = d0; v.seg[1] = d1; v.seg[2] = d2;
    v.seg[3] = d3; v.seg[4] = d4; v.seg[5] = d5;
    return v;
  endfunction

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tick every SCAN_DIV cycles since release, digit = ticks mod 6,
  // snapshot at digit 0, blink phase from whole frames counted since reset/last set entry.
  int          m_cyc = 0, m_ticks = 0, m_frames = 0;
  int          m_sec = 0, m_min = 0, m_hour = 0;
  logic        m_prev_man = 1'b0;
  logic [10:0] exp_tube = '0;

  initial begin
    int   dig;
    logic rise;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_cyc = 0; m_ticks = 0; m_frames = 0;
        m_sec = 0; m_min = 0; m_hour = 0;
        m_prev_man = 1'b0; exp_tube = '0;
      end else begin
        rise       = is_manual_set && !m_prev_man;
        m_prev_man = is_manual_set;
        if (rise) m_frames = 0;
        if (m_cyc % SCAN_DIV == SCAN_DIV - 1) begin
          m_ticks = m_ticks + 1;
          dig     = m_ticks % 6;
          if (dig == 0) begin
            m_sec = int'(sec_count); m_min = int'(min_count); m_hour = int'(hour_count);
            if (!rise) m_frames = m_frames + 1;
          end
          exp_tube = model_digit(dig, m_sec, m_min, m_hour,
                                 is_manual_set && ((m_frames / BLINK_FRAMES) % 2 == 1));
        end
        m_cyc = m_cyc + 1;
      end
    end
  end

  always @(negedge clk) if (mon_en) chk("model", tube_11bit, exp_tube);

  task automatic set_in(input int s, input int m, input int h);
    sec_count = 7'(s); min_count = 7'(m); hour_count = 7'(h);
  endtask

  task automatic wait_frame_start();
    logic [2:0] prev;
    prev = tube_11bit[10:8];
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tube_11bit[10:8] == 3'd0 && prev != 3'd0) return;
      prev = tube_11bit[10:8];
    end
    checks++;
    errors++;
    $display("FAIL frame_start: timeout, select %0d expected 0", tube_11bit[10:8]);
  endtask

  task automatic read_frame(input int r, input logic blank);
    for (int d = 0; d < 6; d++) begin
      logic [10:0] e;
      if (blank && d >= 2) e = {3'(d), 8'h00};
      else                 e = {3'(d), (d == 2 || d == 4) ? 1'b1 : 1'b0, recs[r].seg[d]};
      chk($sformatf("frame%0d_blank%0d_dig%0d", r, blank, d), tube_11bit, e);
      repeat (SCAN_DIV) @(negedge clk);
    end
  endtask

  // Called just after rst rises; expects the all-zero partial frame, then 37/05/23.
  task automatic check_reset_release();
    chk("rst_hold", tube_11bit, 11'h000);
    for (int i = 0; i < SCAN_DIV - 1; i++) begin
      @(negedge clk);
      chk("pre_tick", tube_11bit, 11'h000);
    end
    @(negedge clk);
    for (int d = 1; d < 6; d++) begin
      chk($sformatf("first_frame_dig%0d", d), tube_11bit,
          {3'(d), (d == 2 || d == 4) ? 1'b1 : 1'b0, 7'h3F});
      repeat (SCAN_DIV) @(negedge clk);
    end
    read_frame(0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    recs[0] = mk(37,   5, 23, 7'h07, 7'h4F, 7'h6D, 7'h3F, 7'h4F, 7'h5B);
    recs[1] = mk( 0,   0,  0, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    recs[2] = mk(59,  59, 23, 7'h6F, 7'h6D, 7'h6F, 7'h6D, 7'h4F, 7'h5B);
    recs[3] = mk(38,  12,100, 7'h7F, 7'h4F, 7'h5B, 7'h06, 7'h40, 7'h40);
    recs[4] = mk(127, 99, 64, 7'h40, 7'h40, 7'h6F, 7'h6F, 7'h66, 7'h7D);
    recs[5] = mk(10,  40,  8, 7'h3F, 7'h06, 7'h3F, 7'h66, 7'h7F, 7'h3F);
    recs[6] = mk(38,  47, 23, 7'h7F, 7'h4F, 7'h07, 7'h66, 7'h4F, 7'h5B);

    set_in(37, 5, 23);
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    #1 rst = 1'b1;
    check_reset_release();

    // Mid-frame input changes stay invisible until the next frame.
    repeat (SCAN_DIV) @(negedge clk);
    chk("mid_dig1", tube_11bit, {3'd1, 1'b0, 7'h4F});
    min_count = 7'd47;
    repeat (SCAN_DIV) @(negedge clk);
    chk("mid_dig2_old", tube_11bit, {3'd2, 1'b1, 7'h6D});
    repeat (SCAN_DIV) @(negedge clk);
    chk("mid_dig3_old", tube_11bit, {3'd3, 1'b0, 7'h3F});
    sec_count = 7'd38;
    repeat (SCAN_DIV) @(negedge clk);
    chk("mid_dig4", tube_11bit, {3'd4, 1'b1, 7'h4F});
    repeat (SCAN_DIV) @(negedge clk);
    chk("mid_dig5", tube_11bit, {3'd5, 1'b0, 7'h5B});
    repeat (SCAN_DIV) @(negedge clk);
    read_frame(6, 1'b0);

    // Table of whole frames.
    for (int r = 0; r < 6; r++) begin
      set_in(recs[r].sec, recs[r].min, recs[r].hour);
      wait_frame_start();
      read_frame(r, 1'b0);
    end

    // All fields roll over at once on a frame boundary.
    set_in(59, 59, 23);
    wait_frame_start();
    read_frame(2, 1'b0);
    repeat (5 * SCAN_DIV) @(negedge clk);
    set_in(0, 0, 0);
    chk("rollover_dig5_old", tube_11bit, {3'd5, 1'b0, 7'h5B});
    repeat (SCAN_DIV) @(negedge clk);
    read_frame(1, 1'b0);

    // Set mode: two visible frames, two blanked, then visible again.
    set_in(37, 5, 23);
    wait_frame_start();
    is_manual_set = 1'b1;
    repeat (6 * SCAN_DIV) @(negedge clk);
    read_frame(0, 1'b0);
    read_frame(0, 1'b1);
    read_frame(0, 1'b1);
    read_frame(0, 1'b0);
    is_manual_set = 1'b0;

    // One-cycle reset in mid-frame.
    repeat (3 * SCAN_DIV) @(negedge clk);
    #1 rst = 1'b0;
    #1 chk("rst_async", tube_11bit, 11'h000);
    @(negedge clk);
    #1 rst = 1'b1;
    check_reset_release();

    // Random stimulus against the reference model.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) begin
        sec_count  = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(100, 127)) : 7'($urandom_range(0, 99));
        min_count  = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(100, 127)) : 7'($urandom_range(0, 99));
        hour_count = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(100, 127)) : 7'($urandom_range(0, 99));
      end
      if ($urandom_range(0, 149) == 0) is_manual_set = ~is_manual_set;
      if ($urandom_range(0, 1499) == 0) begin
        #1 rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
